// File: rtl/iter_addsub.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock over a registered carry
// and returns the result with carry/overflow/zero/negative flags under valid/ready.
module iter_addsub #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] ina,
   input  logic [WIDTH-1:0] inb,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             carry,
   output logic             overflow,
   output logic             zero,
   output logic             negative
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   generate
      if (WIDTH % CHUNK != 0) begin : g_bad_chunk
         $error("iter_addsub: WIDTH must be a multiple of CHUNK");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  a_q, b_q, acc_q, acc_d;
   logic              cin_q;
   logic [CW-1:0]     cnt_q;
   logic [CHUNK:0]    sum;
   logic              last;
   logic              accept;

   assign in_ready = (state_q == IDLE);
   assign accept   = in_valid && in_ready;

   // Operands are shifted right each CALC cycle, so the active chunk is always
   // the low CHUNK bits; the result shifts in from the top.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      sum   = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + (CHUNK+1)'(cin_q);
      acc_d = WIDTH'({sum[CHUNK-1:0], acc_q} >> CHUNK);
      last  = (cnt_q == CW'(NCHUNK - 1));
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)    state_d = CALC;
         CALC:    if (last)      state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // NOTE: pure datapath registers are left unreset; they are always loaded before use.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_q <= ina;
         b_q <= sub ? ~inb : inb;
      end else if (state_q == CALC) begin
         a_q   <= a_q >> CHUNK;
         b_q   <= b_q >> CHUNK;
         acc_q <= acc_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cin_q     <= 1'b0;
         cnt_q     <= '0;
         out_valid <= 1'b0;
         out       <= '0;
         carry     <= 1'b0;
         overflow  <= 1'b0;
         zero      <= 1'b0;
         negative  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  cin_q <= sub;
                  cnt_q <= '0;
               end
            end
            CALC: begin
               cin_q <= sum[CHUNK];
               cnt_q <= cnt_q + CW'(1);
               if (last) begin
                  // On the last chunk the low bits of a_q/b_q hold the operand MSBs.
                  out_valid <= 1'b1;
                  out       <= acc_d;
                  carry     <= sum[CHUNK];
                  overflow  <= (a_q[CHUNK-1] == b_q[CHUNK-1]) && (sum[CHUNK-1] != a_q[CHUNK-1]);
                  zero      <= (acc_d == '0);
                  negative  <= sum[CHUNK-1];
               end
            end
            DONE: begin
               if (out_ready) out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_iter_addsub.sv
// Bench for iter_addsub: directed vectors, DONE backpressure, mid-op reset and
// random operations against a reference model, on WIDTH=32 with CHUNK=8 and CHUNK=32.
module tb_iter_addsub;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        iv8, iv32;
   logic [31:0] ina, inb;
   logic        sub;
   logic        out_ready;

   logic        ir8, vld8, c8, v8, z8, n8;
   logic [31:0] o8;
   logic        ir32, vld32, c32, v32, z32, n32;
   logic [31:0] o32;

   int          sel;
   logic        s_ir, s_vld;
   logic [35:0] s_res;

   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   iter_addsub #(.WIDTH(32), .CHUNK(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
      .ina(ina), .inb(inb), .sub(sub), .out_valid(vld8), .out_ready(out_ready),
      .out(o8), .carry(c8), .overflow(v8), .zero(z8), .negative(n8));

   iter_addsub #(.WIDTH(32), .CHUNK(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
      .ina(ina), .inb(inb), .sub(sub), .out_valid(vld32), .out_ready(out_ready),
      .out(o32), .carry(c32), .overflow(v32), .zero(z32), .negative(n32));

   always_comb begin
      s_ir  = ir8;
      s_vld = vld8;
      s_res = {o8, c8, v8, z8, n8};
      if (sel != 0) begin
         s_ir  = ir32;
         s_vld = vld32;
         s_res = {o32, c32, v32, z32, n32};
      end
   end

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic [35:0] exp;   // {out, carry, overflow, zero, negative}
   } vec_t;

   vec_t vt [9];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
      logic [32:0] t;
      logic        v;
      if (s) t = {1'b0, a} + {1'b0, ~b} + 33'd1;
      else   t = {1'b0, a} + {1'b0, b};
      if (s) v = (a[31] != b[31]) && (t[31] != a[31]);
      else   v = (a[31] == b[31]) && (t[31] != a[31]);
      return {t[31:0], t[32], v, (t[31:0] == 32'h0), t[31]};
   endfunction

   // Called at a negedge; returns at a negedge after the output handshake.
   task automatic do_op(input int w, input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int hold, output logic [35:0] got, output int lat);
      int n;
      sel = w;
      ina = a;
      inb = b;
      sub = s;
      if (w != 0) iv32 = 1'b1;
      else        iv8  = 1'b1;
      #1;
      n = 0;
      while (!s_ir && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("in_ready_timeout", {63'h0, s_ir}, 64'h1);
      @(posedge clk);
      #1;
      iv8  = 1'b0;
      iv32 = 1'b0;
      lat  = 0;
      while (lat < 64) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (s_vld) break;
      end
      got = s_res;
      repeat (hold) @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check($sformatf("handshake_w%0d", w), {62'h0, s_vld, s_ir}, 64'h1);
      @(negedge clk);
   endtask

   initial begin
      logic [35:0] got, exp;
      logic [31:0] ra, rb;
      logic        rs;
      int          lat;

      vt[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, {32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0}};
      vt[1] = '{32'h80000000, 32'h00000001, 1'b1, {32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0}};
      vt[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, {32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1}};
      vt[3] = '{32'h00000005, 32'h00000007, 1'b1, {32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1}};
      vt[4] = '{32'h00000003, 32'h00000004, 1'b0, {32'h00000007, 1'b0, 1'b0, 1'b0, 1'b0}};
      vt[5] = '{32'h12345678, 32'h12345678, 1'b1, {32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0}};
      vt[6] = '{32'h80000000, 32'h80000000, 1'b0, {32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0}};
      vt[7] = '{32'h000000FF, 32'h00000001, 1'b0, {32'h00000100, 1'b0, 1'b0, 1'b0, 1'b0}};
      vt[8] = '{32'h00000000, 32'h00000001, 1'b1, {32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1}};

      sel = 0;
      rst_n = 1'b0;
      iv8 = 1'b0;
      iv32 = 1'b0;
      ina = '0;
      inb = '0;
      sub = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_w8",  {ir8,  vld8,  o8,  c8,  v8,  z8,  n8},  {2'b10, 36'h0});
      check("reset_w32", {ir32, vld32, o32, c32, v32, z32, n32}, {2'b10, 36'h0});
      rst_n = 1'b1;
      @(negedge clk);

      // Directed vectors on both configurations.
      for (int w = 0; w < 2; w++) begin
         for (int i = 0; i < 9; i++) begin
            do_op(w, vt[i].a, vt[i].b, vt[i].s, i % 3, got, lat);
            check($sformatf("vec%0d_w%0d", i, w), got, vt[i].exp);
            check($sformatf("latency_vec%0d_w%0d", i, w), lat, (w != 0) ? 1 : 4);
         end
      end

      // DONE held with out_ready low while new operands are offered.
      sel = 0;
      ina = 32'h7FFFFFFF;
      inb = 32'h00000001;
      sub = 1'b0;
      iv8 = 1'b1;
      @(posedge clk);
      #1 iv8 = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      exp = {32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1};
      check("hold_first", {vld8, ir8, o8, c8, v8, z8, n8}, {2'b10, exp});
      for (int k = 0; k < 5; k++) begin
         ina = 32'hFFFFFFFF;
         inb = 32'h00000001;
         sub = 1'b1;
         iv8 = 1'b1;
         @(posedge clk);
         @(negedge clk);
         check($sformatf("hold_stable%0d", k), {vld8, ir8, o8, c8, v8, z8, n8}, {2'b10, exp});
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      iv8 = 1'b0;
      check("hold_release", {vld8, ir8, o8, c8, v8, z8, n8}, {2'b01, exp});
      repeat (6) @(negedge clk);
      check("hold_no_capture", {vld8, ir8}, 2'b01);

      // Reset in the middle of CALC aborts the operation.
      ina = 32'hFFFFFFFF;
      inb = 32'h00000001;
      sub = 1'b0;
      iv8 = 1'b1;
      @(posedge clk);
      #1 iv8 = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midcalc_reset", {vld8, ir8, o8, c8, v8, z8, n8}, {2'b01, 36'h0});
      ina = 32'h00000001;
      inb = 32'h00000001;
      iv8 = 1'b1;
      @(posedge clk);
      #1;
      check("reset_no_capture", {vld8, ir8, o8}, {2'b01, 32'h0});
      iv8 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_op(0, 32'h00000003, 32'h00000004, 1'b0, 0, got, lat);
      check("after_reset_op", got, {32'h00000007, 4'b0000});
      check("after_reset_latency", lat, 4);

      // Random operations with random output backpressure.
      for (int w = 0; w < 2; w++) begin
         for (int i = 0; i < 2500; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            if (i % 8 == 0) rb = rs ? ra : ~ra;
            do_op(w, ra, rb, rs, $urandom_range(0, 3), got, lat);
            check($sformatf("rand%0d_w%0d a=%h b=%h sub=%0d", i, w, ra, rb, rs), got, model(ra, rb, rs));
            check($sformatf("rand_latency%0d_w%0d", i, w), lat, (w != 0) ? 1 : 4);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
